// File: rtl/fifo_uart_tx.sv
// Drain stage for a 16x16 synchronous FIFO: pops one word at a time and sends it
// as two 8N1 UART frames, low byte first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic             byte_sel, byte_sel_next;
  logic [15:0]      word, word_next;
  logic             bit_end;
  logic [7:0]       cur_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_sel <= 1'b0;
      word     <= 16'd0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      byte_sel <= byte_sel_next;
      word     <= word_next;
    end
  end

  assign bit_end = (cnt == CNT_LAST);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    byte_sel_next = byte_sel;
    word_next     = word;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (enable && !fifo_empty) begin
          state_next = POP;
        end else begin
          state_next = IDLE;
        end
      end
      POP: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      // fifo_data is the FIFO's registered output, valid only now, after the pop
      WAIT: begin
        cnt_next      = '0;
        word_next     = fifo_data;
        byte_sel_next = 1'b0;
        state_next    = START;
      end
      START: begin
        if (bit_end) begin
          cnt_next     = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (!byte_sel) begin
            byte_sel_next = 1'b1;
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign cur_byte = byte_sel ? word[15:8] : word[7:0];

  // Outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  assign fifo_read = (state == POP);
  assign busy      = (state != IDLE);
  assign word_done = (state == STOP) && bit_end && byte_sel;

endmodule
